mem_stage: RTL and testbench

//  Memory-access stage between AGEX_STAGE and WB_STAGE. Consumes AGEX latch, issues loads/stores
//  to a variable-latency data-memory port (req/gnt/rvalid), aligns and extends load data.

---
 rtl/mem_stage_pkg.sv | 88 ++++++++
 rtl/mem_stage_lane_align.sv | 39 +++
 rtl/mem_stage.sv | 126 ++++++++++++
 tb/tb_mem_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: latch layouts, opcodes, FSM encodings
// and small opcode-classification helpers.
package mem_stage_pkg;

   localparam int DATA_W  = 32;
   localparam int REGNO_W = 5;
   localparam int OP_W    = 5;

   localparam logic [OP_W-1:0] ADD_I = 5'd0;
   localparam logic [OP_W-1:0] LB_I  = 5'd1;
   localparam logic [OP_W-1:0] LH_I  = 5'd2;
   localparam logic [OP_W-1:0] LW_I  = 5'd3;
   localparam logic [OP_W-1:0] LBU_I = 5'd4;
   localparam logic [OP_W-1:0] LHU_I = 5'd5;
   localparam logic [OP_W-1:0] SB_I  = 5'd6;
   localparam logic [OP_W-1:0] SH_I  = 5'd7;
   localparam logic [OP_W-1:0] SW_I  = 5'd8;

   typedef enum logic [1:0] {
      MEM_IDLE    = 2'd0,
      MEM_REQ     = 2'd1,
      MEM_WAIT_RD = 2'd2
   } mem_state_t;

   typedef struct packed {
      logic                valid;
      logic [DATA_W-1:0]   inst;
      logic [DATA_W-1:0]   pc;
      logic [OP_W-1:0]     op_i;
      logic [DATA_W-1:0]   inst_count;
      logic [DATA_W-1:0]   arith;
      logic [DATA_W-1:0]   rs2_val;
      logic [REGNO_W-1:0]  rd;
      logic                reg_wr;
   } agex_latch_t;

   typedef struct packed {
      logic                valid;
      logic [DATA_W-1:0]   inst;
      logic [DATA_W-1:0]   pc;
      logic [OP_W-1:0]     op_i;
      logic [DATA_W-1:0]   inst_count;
      logic [DATA_W-1:0]   result;
      logic [REGNO_W-1:0]  rd;
      logic                reg_wr;
      logic                misalign;
   } mem_latch_t;

   localparam int AGEX_LATCH_W  = $bits(agex_latch_t);
   localparam int MEM_LATCH_W   = $bits(mem_latch_t);
   localparam int MEM_TO_AGEX_W = 1;
   localparam int MEM_TO_DE_W   = 1 + REGNO_W + DATA_W;
   localparam int WB_TO_MEM_W   = 1;

   function automatic logic is_load(input logic [OP_W-1:0] op);
      return op inside {LB_I, LH_I, LW_I, LBU_I, LHU_I};
   endfunction

   function automatic logic is_store(input logic [OP_W-1:0] op);
      return op inside {SB_I, SH_I, SW_I};
   endfunction

   function automatic logic is_mem(input logic [OP_W-1:0] op);
      return is_load(op) | is_store(op);
   endfunction

   function automatic logic is_misaligned(input logic [OP_W-1:0] op, input logic [1:0] a);
      if (op inside {LH_I, LHU_I, SH_I}) return a[0];
      if (op inside {LW_I, SW_I})        return |a;
      return 1'b0;
   endfunction

   function automatic mem_latch_t make_mem_latch(input agex_latch_t a, input logic [DATA_W-1:0] result,
                                                 input logic reg_wr, input logic misalign);
      mem_latch_t m;
      m.valid      = 1'b1;
      m.inst       = a.inst;
      m.pc         = a.pc;
      m.op_i       = a.op_i;
      m.inst_count = a.inst_count;
      m.result     = result;
      m.rd         = a.rd;
      m.reg_wr     = reg_wr;
      m.misalign   = misalign;
      return m;
   endfunction

endpackage

// File: rtl/mem_stage_lane_align.sv
// Byte-lane steering for the data-memory port: store byte enables and replicated
// write data, plus load lane extraction with sign/zero extension.
module mem_lane_align
   import mem_stage_pkg::*;
(
   input  logic [OP_W-1:0]   op,
   input  logic [1:0]        addr_lo,
   input  logic [DATA_W-1:0] rs2,
   input  logic [DATA_W-1:0] rdata,
   output logic [3:0]        be,
   output logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] load_data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Sub-size address bits are dropped, so an unaligned access lands on its aligned container.
   assign byte_v = rdata[{addr_lo, 3'b000} +: 8];
   assign half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      be        = 4'b0000;
      wdata     = '0;
      load_data = rdata;
      case (op)
         LB_I:  begin be = 4'b0001 << addr_lo;             load_data = {{24{byte_v[7]}}, byte_v};  end
         LBU_I: begin be = 4'b0001 << addr_lo;             load_data = {24'h0, byte_v};            end
         LH_I:  begin be = 4'b0011 << {addr_lo[1], 1'b0};  load_data = {{16{half_v[15]}}, half_v}; end
         LHU_I: begin be = 4'b0011 << {addr_lo[1], 1'b0};  load_data = {16'h0, half_v};            end
         LW_I:  be = 4'b1111;
         SB_I:  begin be = 4'b0001 << addr_lo;             wdata = {4{rs2[7:0]}};  end
         SH_I:  begin be = 4'b0011 << {addr_lo[1], 1'b0};  wdata = {2{rs2[15:0]}}; end
         SW_I:  begin be = 4'b1111;                        wdata = rs2;            end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores on a req/gnt/rvalid port, stalls upstream
// while in flight, and writes the MEM latch. Optional MEM_MISALIGN_TRAP_EN flags misaligned accesses.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DBITS     = DATA_W,
   parameter int REGNOBITS = REGNO_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [AGEX_LATCH_W-1:0]    from_AGEX_latch,
   input  logic [WB_TO_MEM_W-1:0]     from_WB_to_MEM,
   output logic [MEM_LATCH_W-1:0]     MEM_latch_out,
   output logic [MEM_TO_AGEX_W-1:0]   from_MEM_to_AGEX,
   output logic [REGNOBITS+DBITS:0]   from_MEM_to_DE,
   output logic                       dmem_req,
   output logic                       dmem_we,
   output logic [DBITS-1:0]           dmem_addr,
   output logic [DBITS-1:0]           dmem_wdata,
   output logic [3:0]                 dmem_be,
   input  logic                       dmem_gnt,
   input  logic                       dmem_rvalid,
   input  logic [DBITS-1:0]           dmem_rdata,
   output logic [1:0]                 dbg_state
);

   agex_latch_t agex, acc_q;
   mem_latch_t  mem_q, mem_d;
   mem_state_t  state, state_nxt;
   logic        trap, agex_mem, mem_stall, acc_store;
   logic [3:0]        lane_be;
   logic [DATA_W-1:0] lane_wdata, load_data;
   logic [WB_TO_MEM_W:0] unused_bits;

   assign agex      = agex_latch_t'(from_AGEX_latch);
   assign acc_store = is_store(acc_q.op_i);

`ifdef MEM_MISALIGN_TRAP_EN
   assign trap = agex.valid & is_mem(agex.op_i) & is_misaligned(agex.op_i, agex.arith[1:0]);
`else
   assign trap = 1'b0;
`endif
   assign agex_mem = agex.valid & is_mem(agex.op_i) & ~trap;

   mem_lane_align u_align (
      .op        (acc_q.op_i),
      .addr_lo   (acc_q.arith[1:0]),
      .rs2       (acc_q.rs2_val),
      .rdata     (dmem_rdata),
      .be        (lane_be),
      .wdata     (lane_wdata),
      .load_data (load_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= MEM_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         MEM_IDLE:    if (agex_mem)    state_nxt = MEM_REQ;
         MEM_REQ:     if (dmem_gnt)    state_nxt = acc_store ? MEM_IDLE : MEM_WAIT_RD;
         MEM_WAIT_RD: if (dmem_rvalid) state_nxt = MEM_IDLE;
         default:                      state_nxt = MEM_IDLE;
      endcase
   end

   // Port signals are driven only in REQ so the request is quiet outside a handshake.
   always_comb begin
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = '0;
      dmem_wdata = '0;
      dmem_be    = 4'b0000;
      mem_stall  = 1'b0;
      case (state)
         MEM_IDLE: mem_stall = agex_mem;
         MEM_REQ: begin
            dmem_req   = 1'b1;
            dmem_we    = acc_store;
            dmem_addr  = {acc_q.arith[DATA_W-1:2], 2'b00};
            dmem_wdata = lane_wdata;
            dmem_be    = lane_be;
            mem_stall  = ~(acc_store & dmem_gnt);
         end
         MEM_WAIT_RD: mem_stall = ~dmem_rvalid;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                          acc_q <= '0;
      else if (state == MEM_IDLE && agex_mem) acc_q <= agex;
   end

   // Anything other than a completing cycle writes a bubble.
   always_comb begin
      mem_d = '0;
      case (state)
         MEM_IDLE:
            if (agex.valid && (!is_mem(agex.op_i) || trap))
               mem_d = make_mem_latch(agex, agex.arith, agex.reg_wr & ~trap & ~is_store(agex.op_i), trap);
         MEM_REQ:
            if (dmem_gnt && acc_store)
               mem_d = make_mem_latch(acc_q, acc_q.arith, 1'b0, 1'b0);
         MEM_WAIT_RD:
            if (dmem_rvalid)
               mem_d = make_mem_latch(acc_q, load_data, acc_q.reg_wr, 1'b0);
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) mem_q <= '0;
      else        mem_q <= mem_d;
   end

   assign MEM_latch_out    = mem_q;
   assign from_MEM_to_AGEX = mem_stall;
   assign from_MEM_to_DE   = {mem_q.valid & mem_q.reg_wr & (mem_q.rd != '0), mem_q.rd, mem_q.result};
   assign dbg_state        = state;
   assign unused_bits      = {from_WB_to_MEM, acc_q.valid};

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; define MEM_MISALIGN_TRAP_EN to cover
// the misalignment trap build.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic clk = 1'b0;
   logic reset;
   agex_latch_t agex;
   logic [WB_TO_MEM_W-1:0] from_wb;
   logic [MEM_LATCH_W-1:0] mem_out;
   logic [MEM_TO_AGEX_W-1:0] stall;
   logic [MEM_TO_DE_W-1:0] to_de;
   logic dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0] dmem_be;
   logic [1:0] dbg_state;
   mem_latch_t ml;
   int total = 0;
   int bad = 0;
   int icount = 0;

   assign ml = mem_latch_t'(mem_out);

   always #5 clk = ~clk;

   mem_stage dut (
      .clk (clk), .reset (reset),
      .from_AGEX_latch (agex), .from_WB_to_MEM (from_wb),
      .MEM_latch_out (mem_out), .from_MEM_to_AGEX (stall), .from_MEM_to_DE (to_de),
      .dmem_req (dmem_req), .dmem_we (dmem_we), .dmem_addr (dmem_addr),
      .dmem_wdata (dmem_wdata), .dmem_be (dmem_be), .dmem_gnt (dmem_gnt),
      .dmem_rvalid (dmem_rvalid), .dmem_rdata (dmem_rdata), .dbg_state (dbg_state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_agex(input logic [4:0] op, input logic [31:0] arith, input logic [31:0] rs2,
                           input logic [4:0] rd, input logic reg_wr);
      icount++;
      agex            = '0;
      agex.valid      = 1'b1;
      agex.inst       = 32'h0A00_0000 | 32'(op);
      agex.pc         = 32'h0000_4000 + 32'(icount * 4);
      agex.op_i       = op;
      agex.inst_count = 32'(icount);
      agex.arith      = arith;
      agex.rs2_val    = rs2;
      agex.rd         = rd;
      agex.reg_wr     = reg_wr;
   endtask

   task automatic test_reset();
      reset = 1'b0; agex = '0; from_wb = '0;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
      #1;
      total++; if (mem_out !== '0) begin bad++; $display("FAIL reset_latch: got %h want 0", mem_out); end
      total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", dmem_req); end
      tick(); tick();
      reset = 1'b1;
      tick();
      total++; if (dbg_state !== MEM_IDLE) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
      total++; if (to_de !== '0) begin bad++; $display("FAIL reset_fwd: got %h want 0", to_de); end
      total++; if ({dmem_we, dmem_addr, dmem_wdata, dmem_be} !== '0) begin bad++;
         $display("FAIL reset_port: got we=%b addr=%h wdata=%h be=%b want all 0", dmem_we, dmem_addr, dmem_wdata, dmem_be); end
      total++; if (mem_out !== '0) begin bad++; $display("FAIL reset_latch_rel: got %h want 0", mem_out); end
   endtask

   task automatic test_alu();
      set_agex(ADD_I, 32'h1234, 32'h0, 5'd3, 1'b1);
      dmem_gnt = 1'b1;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall: got %b want 0", stall); end
      total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL alu_req: got %b want 0", dmem_req); end
      tick();
      total++; if (ml.valid !== 1'b1 || ml.result !== 32'h1234 || ml.rd !== 5'd3 || ml.reg_wr !== 1'b1) begin bad++;
         $display("FAIL alu_latch: got v=%b res=%h rd=%0d wr=%b want v=1 res=1234 rd=3 wr=1", ml.valid, ml.result, ml.rd, ml.reg_wr); end
      total++; if (to_de !== {1'b1, 5'd3, 32'h1234}) begin bad++; $display("FAIL alu_fwd: got %h want %h", to_de, {1'b1, 5'd3, 32'h1234}); end
      total++; if (dbg_state !== MEM_IDLE) begin bad++; $display("FAIL alu_state: got %0d want 0", dbg_state); end
      set_agex(ADD_I, 32'h55, 32'h0, 5'd0, 1'b1);
      tick();
      total++; if (ml.valid !== 1'b1 || ml.result !== 32'h55) begin bad++; $display("FAIL alu_b2b: got v=%b res=%h want v=1 res=55", ml.valid, ml.result); end
      total++; if (to_de[37] !== 1'b0) begin bad++; $display("FAIL alu_fwd_rd0: got %b want 0", to_de[37]); end
      agex.valid = 1'b0; dmem_gnt = 1'b0;
      tick();
      total++; if (ml.valid !== 1'b0 || to_de[37] !== 1'b0) begin bad++; $display("FAIL alu_idle: got v=%b fwd=%b want 0 0", ml.valid, to_de[37]); end
   endtask

   task automatic run_access(input string name, input logic [4:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                             input int gnt_wait, input int rv_wait, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input logic [31:0] exp_result);
      logic st;
      int stalls, exp_stalls;
      st = (op == SB_I || op == SH_I || op == SW_I);
      stalls = 0;
      exp_stalls = st ? 1 + gnt_wait : 2 + gnt_wait + rv_wait;
      set_agex(op, addr, rs2, 5'd7, 1'b1);
      #1;
      if (stall === 1'b1) stalls++;
      total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL %s idle_req: got %b want 0", name, dmem_req); end
      tick();
      total++; if (dmem_req !== 1'b1 || dmem_we !== st || dmem_addr !== exp_addr || dmem_be !== exp_be) begin bad++;
         $display("FAIL %s port: got req=%b we=%b addr=%h be=%b want 1 %b %h %b", name, dmem_req, dmem_we, dmem_addr, dmem_be, st, exp_addr, exp_be); end
      if (st) begin
         total++; if (dmem_wdata !== exp_wdata) begin bad++; $display("FAIL %s wdata: got %h want %h", name, dmem_wdata, exp_wdata); end
      end
      for (int i = 0; i < gnt_wait; i++) begin
         if (stall === 1'b1) stalls++;
         total++; if (ml.valid !== 1'b0 || dmem_req !== 1'b1) begin bad++;
            $display("FAIL %s gnt_wait: got v=%b req=%b want 0 1", name, ml.valid, dmem_req); end
         tick();
      end
      dmem_gnt = 1'b1;
      #1;
      if (stall === 1'b1) stalls++;
      tick();
      dmem_gnt = 1'b0;
      if (!st) begin
         total++; if (dbg_state !== MEM_WAIT_RD || dmem_req !== 1'b0 || ml.valid !== 1'b0) begin bad++;
            $display("FAIL %s wait_rd: got st=%0d req=%b v=%b want 2 0 0", name, dbg_state, dmem_req, ml.valid); end
         dmem_rdata = 32'hDEAD_DEAD;
         for (int i = 0; i < rv_wait; i++) begin
            if (stall === 1'b1) stalls++;
            tick();
            total++; if (ml.valid !== 1'b0) begin bad++; $display("FAIL %s rv_bubble: got v=%b want 0", name, ml.valid); end
         end
         dmem_rvalid = 1'b1; dmem_rdata = rdata;
         #1;
         if (stall === 1'b1) stalls++;
         tick();
         dmem_rvalid = 1'b0;
      end
      agex.valid = 1'b0;
      total++; if (ml.valid !== 1'b1 || ml.result !== exp_result || ml.reg_wr !== !st || ml.op_i !== op || ml.misalign !== 1'b0) begin bad++;
         $display("FAIL %s latch: got v=%b res=%h wr=%b op=%0d mis=%b want 1 %h %b %0d 0", name, ml.valid, ml.result, ml.reg_wr, ml.op_i, ml.misalign, exp_result, !st, op); end
      total++; if (dbg_state !== MEM_IDLE) begin bad++; $display("FAIL %s done_state: got %0d want 0", name, dbg_state); end
      total++; if (stalls != exp_stalls) begin bad++; $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls, exp_stalls); end
      tick();
      total++; if (ml.valid !== 1'b0) begin bad++; $display("FAIL %s once: got v=%b want 0", name, ml.valid); end
   endtask

   task automatic test_stores();
      run_access("sb", SB_I, 32'h103, 32'h0000_00AB, 2, 0, 32'h0, 32'h100, 4'b1000, 32'hABAB_ABAB, 32'h103);
      run_access("sh", SH_I, 32'h102, 32'h1234_ABCD, 0, 0, 32'h0, 32'h100, 4'b1100, 32'hABCD_ABCD, 32'h102);
      run_access("sw", SW_I, 32'h204, 32'hCAFE_F00D, 1, 0, 32'h0, 32'h204, 4'b1111, 32'hCAFE_F00D, 32'h204);
   endtask

   task automatic test_loads();
      run_access("lb", LB_I, 32'h102, 32'h0, 0, 0, 32'h0080_0000, 32'h100, 4'b0100, 32'h0, 32'hFFFF_FF80);
      run_access("lbu", LBU_I, 32'h102, 32'h0, 0, 0, 32'h0080_0000, 32'h100, 4'b0100, 32'h0, 32'h0000_0080);
      run_access("lh", LH_I, 32'h102, 32'h0, 1, 2, 32'h8001_0000, 32'h100, 4'b1100, 32'h0, 32'hFFFF_8001);
      run_access("lhu", LHU_I, 32'h102, 32'h0, 0, 1, 32'h8001_0000, 32'h100, 4'b1100, 32'h0, 32'h0000_8001);
      run_access("lb_pos", LB_I, 32'h100, 32'h0, 0, 0, 32'h0000_007F, 32'h100, 4'b0001, 32'h0, 32'h0000_007F);
      run_access("lw", LW_I, 32'h208, 32'h0, 2, 0, 32'h1234_5678, 32'h208, 4'b1111, 32'h0, 32'h1234_5678);
   endtask

   task automatic test_reset_mid();
      set_agex(LB_I, 32'h100, 32'h0, 5'd4, 1'b1);
      tick();
      total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL rst_mid_req: got %b want 1", dmem_req); end
      dmem_gnt = 1'b1;
      tick();
      dmem_gnt = 1'b0;
      total++; if (dbg_state !== MEM_WAIT_RD) begin bad++; $display("FAIL rst_mid_wait: got %0d want 2", dbg_state); end
      reset = 1'b0; agex.valid = 1'b0;
      #1;
      total++; if (dbg_state !== MEM_IDLE || dmem_req !== 1'b0 || ml.valid !== 1'b0) begin bad++;
         $display("FAIL rst_mid_async: got st=%0d req=%b v=%b want 0 0 0", dbg_state, dmem_req, ml.valid); end
      tick();
      reset = 1'b1;
      dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_0011;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_mid_stale_stall: got %b want 0", stall); end
      tick();
      dmem_rvalid = 1'b0;
      total++; if (ml.valid !== 1'b0 || dbg_state !== MEM_IDLE) begin bad++;
         $display("FAIL rst_mid_stale: got v=%b st=%0d want 0 0", ml.valid, dbg_state); end
   endtask

   task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
      set_agex(LW_I, 32'h101, 32'h0, 5'd9, 1'b1);
      #1;
      total++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin bad++; $display("FAIL mis_issue: got stall=%b req=%b want 0 0", stall, dmem_req); end
      tick();
      total++; if (ml.valid !== 1'b1 || ml.misalign !== 1'b1 || ml.reg_wr !== 1'b0 || ml.result !== 32'h101) begin bad++;
         $display("FAIL mis_latch: got v=%b mis=%b wr=%b res=%h want 1 1 0 101", ml.valid, ml.misalign, ml.reg_wr, ml.result); end
      total++; if (dmem_req !== 1'b0 || dbg_state !== MEM_IDLE) begin bad++; $display("FAIL mis_state: got req=%b st=%0d want 0 0", dmem_req, dbg_state); end
      agex.valid = 1'b0;
      tick();
`else
      run_access("lw_unal", LW_I, 32'h101, 32'h0, 0, 0, 32'hDEAD_BEEF, 32'h100, 4'b1111, 32'h0, 32'hDEAD_BEEF);
`endif
   endtask

   initial begin
      test_reset();
      test_alu();
      test_stores();
      test_loads();
      test_reset_mid();
      test_misalign();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
